// File: rtl/osu_sc_bist_pkg.sv
// osu_sc_bist_pkg
// Shared types and helpers for the dff_1 shift-chain BIST sequencer:
// FSM state encoding, LFSR geometry/taps and the LFSR step function.
// Optional feature macro used by the top: OSU_BIST_ERRCNT_EN (err_cnt port).

package osu_sc_bist_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // 16-bit Fibonacci LFSR, taps at bits 15, 13, 12, 10
    localparam int              LFSR_W        = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
    // An all-zero LFSR would lock up, so a zero seed is replaced by this value
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 16'h0001;

    // One LFSR step: shift left, feedback is the XOR of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        logic fb;
        fb = ^(l & LFSR_TAPS);
        return {l[LFSR_W-2:0], fb};
    endfunction

    // Seed actually used by the hardware
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/osu_sc_bist_lfsr16.sv
// osu_sc_bist_lfsr16
// Loadable 16-bit Fibonacci LFSR used both as the pattern generator and as
// the expected-data checker. load has priority over advance; the serial
// output is the MSB of the register.

module osu_sc_bist_lfsr16
    import osu_sc_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = ZERO_SEED_SUB
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              load,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic              bit_out
);

    logic [LFSR_W-1:0] lfsr;

    // LFSR register: reload from seed on load, otherwise step when advancing
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            lfsr <= RESET_VAL;
        end else if (load) begin
            lfsr <= seed;
        end else if (advance) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign bit_out = lfsr[LFSR_W-1];

endmodule

// File: rtl/osu_sc_dff_chain_bist.sv
// osu_sc_dff_chain_bist
// BIST sequencer for an external chain of CHAIN_LEN dff_1 cells. A start
// request arms the sequencer; on the following edge it reloads both LFSRs
// and enters FILL, shifting CHAIN_LEN generator bits into the chain. RUN
// then compares PAT_LEN chain outputs against a checker LFSR that lags the
// generator by exactly the chain length, and DONE reports pass/fail_idx.
// Optional feature: define OSU_BIST_ERRCNT_EN to add the err_cnt port
// (saturating count of all RUN mismatches).

module osu_sc_dff_chain_bist
    import osu_sc_bist_pkg::*;
#(
    parameter int                CHAIN_LEN = 16,
    parameter int                PAT_LEN   = 64,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    localparam int               IDX_W     = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] fail_idx,
    output logic             chain_d,
    output logic             chain_shift,
    input  logic             chain_q
`ifdef OSU_BIST_ERRCNT_EN
    ,
    output logic [$clog2(PAT_LEN+1)-1:0] err_cnt
`endif
);

    // One counter serves both FILL and RUN, sized for the longer phase
    localparam int CNT_MAX = (CHAIN_LEN > PAT_LEN) ? CHAIN_LEN : PAT_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [LFSR_W-1:0] SEED_EFF  = seed_fix(LFSR_SEED);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             start_pend;   // start accepted, FILL begins next edge
    logic             mis_seen;     // at least one RUN mismatch so far

    logic gen_bit;
    logic chk_bit;
    logic lfsr_load;
    logic gen_adv;
    logic chk_adv;
    logic mismatch;
    logic in_run;

    // Both LFSRs reload on the edge that enters FILL; abort cancels that.
    // start_pend is only ever set in IDLE/DONE, so no state qualifier needed.
    assign lfsr_load = start_pend & ~abort;
    assign in_run    = (state == RUN);
    // Generator steps every shifting cycle; checker only while comparing
    assign gen_adv   = busy;
    assign chk_adv   = in_run;
    assign mismatch  = in_run & (chain_q != chk_bit);

    // Chain interface: shift enable follows busy, data is gated to 0 when idle
    assign chain_shift = busy;
    assign chain_d     = busy & gen_bit;

    osu_sc_bist_lfsr16 #(
        .RESET_VAL (SEED_EFF)
    ) u_gen (
        .CLK     (CLK),
        .RN      (RN),
        .load    (lfsr_load),
        .advance (gen_adv),
        .seed    (SEED_EFF),
        .bit_out (gen_bit)
    );

    osu_sc_bist_lfsr16 #(
        .RESET_VAL (SEED_EFF)
    ) u_chk (
        .CLK     (CLK),
        .RN      (RN),
        .load    (lfsr_load),
        .advance (chk_adv),
        .seed    (SEED_EFF),
        .bit_out (chk_bit)
    );

    // Sequencer FSM with registered status outputs; abort overrides everything
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state      <= IDLE;
            cnt        <= '0;
            start_pend <= 1'b0;
            mis_seen   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_idx   <= '0;
        end else if (abort) begin
            state      <= IDLE;
            cnt        <= '0;
            start_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_pend) begin
                        state      <= FILL;
                        start_pend <= 1'b0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_idx   <= '0;
                        mis_seen   <= 1'b0;
                    end else if (start) begin
                        start_pend <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt == FILL_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RUN: begin
                    if (mismatch && !mis_seen) begin
                        mis_seen <= 1'b1;
                        fail_idx <= IDX_W'(cnt);
                    end
                    if (cnt == RUN_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Include the final compare, which is not yet in mis_seen
                        pass  <= ~(mis_seen | mismatch);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef OSU_BIST_ERRCNT_EN
    localparam int              ERR_W   = $clog2(PAT_LEN + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(PAT_LEN);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    // Total RUN mismatches, cleared on each new test, saturating at PAT_LEN
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            err_cnt <= '0;
        end else if (lfsr_load) begin
            err_cnt <= '0;
        end else if (mismatch && !abort && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_ONE;
        end
    end
`endif

endmodule
